// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the layer-2 argmax result block.
package fc_pkg;
  localparam int DW    = 16;
  localparam int N_OUT = 256;
  localparam int IW    = 8;
  localparam int MW    = DW + 1;

  localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/fc_top2_tracker.sv
// Running maximum / second-maximum tracker; compare results are exposed so the
// owner can form the post-update values in the same cycle.
module fc_top2_tracker
  import fc_pkg::*;
#(
  parameter int DW = fc_pkg::DW,
  parameter int IW = fc_pkg::IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          update,
  input  logic [DW-1:0] din,
  input  logic [IW-1:0] din_idx,
  output logic [DW-1:0] max_val,
  output logic [DW-1:0] second_val,
  output logic [IW-1:0] max_idx,
  output logic          gt_max,
  output logic          gt_second
);
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] din_s;
  logic signed [DW-1:0] max_r;
  logic signed [DW-1:0] second_r;
  logic [IW-1:0]        idx_r;

  assign din_s      = din;
  assign gt_max     = din_s > max_r;
  assign gt_second  = din_s > second_r;
  assign max_val    = max_r;
  assign second_val = second_r;
  assign max_idx    = idx_r;

  // Strict compares: an equal value never steals the index but can raise second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_r    <= MIN_V;
      second_r <= MIN_V;
      idx_r    <= '0;
    end else if (clear) begin
      max_r    <= MIN_V;
      second_r <= MIN_V;
      idx_r    <= '0;
    end else if (update) begin
      if (gt_max) begin
        second_r <= max_r;
        max_r    <= din_s;
        idx_r    <= din_idx;
      end else if (gt_second) begin
        second_r <= din_s;
      end
    end
  end
endmodule

// File: rtl/fc_argmax_out.sv
// Collects N_OUT layer-2 scores, reports argmax, max score and top-2 margin
// behind a valid/ack handshake.
module fc_argmax_out
  import fc_pkg::*;
#(
  parameter int N_OUT = fc_pkg::N_OUT,
  parameter int DW    = fc_pkg::DW,
  parameter int IW    = fc_pkg::IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ack,
  output logic [IW-1:0] res_index,
  output logic [DW-1:0] res_value,
  output logic [DW:0]   res_margin,
  output logic          overflow
);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

  state_t               state;
  logic [IW-1:0]        cnt;
  logic [DW-1:0]        max_val;
  logic [DW-1:0]        second_val;
  logic [IW-1:0]        max_idx;
  logic                 gt_max;
  logic                 gt_second;
  logic                 upd;
  logic signed [DW-1:0] nxt_max;
  logic signed [DW-1:0] nxt_second;
  logic [IW-1:0]        nxt_idx;

  function automatic logic [DW:0] top2_margin(input logic signed [DW-1:0] hi,
                                              input logic signed [DW-1:0] lo);
    logic signed [DW:0] diff;
    diff = {hi[DW-1], hi} - {lo[DW-1], lo};
    return diff;
  endfunction

  // A start always wins over a sample in the same cycle.
  assign upd = (state == COLLECT) && in_valid && !start;

  fc_top2_tracker #(.DW(DW), .IW(IW)) u_trk (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .update     (upd),
    .din        (in_data),
    .din_idx    (cnt),
    .max_val    (max_val),
    .second_val (second_val),
    .max_idx    (max_idx),
    .gt_max     (gt_max),
    .gt_second  (gt_second)
  );

  // Post-update tracker view, so the final sample lands in the result directly.
  always_comb begin
    nxt_max    = max_val;
    nxt_second = second_val;
    nxt_idx    = max_idx;
    if (gt_max) begin
      nxt_second = max_val;
      nxt_max    = in_data;
      nxt_idx    = cnt;
    end else if (gt_second) begin
      nxt_second = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_index  <= '0;
      res_value  <= '0;
      res_margin <= '0;
      overflow   <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            busy     <= 1'b1;
            cnt      <= '0;
            overflow <= 1'b0;
          end
        end
        COLLECT: begin
          if (start) begin
            cnt <= '0;
          end else if (in_valid) begin
            if (cnt == LAST_IDX) begin
              state      <= DONE;
              busy       <= 1'b0;
              res_valid  <= 1'b1;
              res_index  <= nxt_idx;
              res_value  <= nxt_max;
              res_margin <= top2_margin(nxt_max, nxt_second);
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            res_valid <= 1'b0;
            cnt       <= '0;
            overflow  <= 1'b0;
          end else begin
            if (in_valid) overflow <= 1'b1;
            if (res_ack) begin
              state     <= IDLE;
              res_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/fc_argmax_out.md
Name: fc_argmax_out

Overview:
- Downstream consumer of the layer-2 result stream: takes each finished neuron value (q2 qualified by wren2) as the second fully connected layer emits it.
- Tracks the running maximum and second maximum over N_OUT results and reports the winning class index, its score and the top-2 margin.
- Result is held behind a valid/ack handshake so the host or test logic can read it at its own pace.

Parameters:
- N_OUT, 256, number of layer-2 outputs per inference.
- DW, 16, score width; signed two's complement.
- IW, 8, index width, equal to clog2(N_OUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new inference (driven from complete1 rising edge).
- in_valid  in  1  score strobe (wren2).
- in_data  in  DW  signed score (q2); sampled only when in_valid=1.
- busy  out  1  high while in COLLECT.
- res_valid  out  1  result available.
- res_ack  in  1  consumer accepts the result; effective only while res_valid=1.
- res_index  out  IW  index of the maximum score (arrival order, 0-based).
- res_value  out  DW  maximum score.
- res_margin  out  DW+1  unsigned (max - second max).
- overflow  out  1  sticky; a sample arrived while in DONE.

Behaviour:
- States: IDLE, COLLECT, DONE. All state-holding logic resets asynchronously.
- Reset values: state=IDLE; busy=0; res_valid=0; res_index=0; res_value=0; res_margin=0; overflow=0; sample counter=0.
- IDLE:
  - in_valid is ignored.
  - start -> COLLECT. Clears counter, overflow, max=MIN_VAL, second=MIN_VAL (MIN_VAL = -2^(DW-1)).
- COLLECT (busy=1): each in_valid sample is assigned index = counter, then the counter increments.
  - If in_data > max (signed, strict): second<=max, max<=in_data, idx<=counter.
  - Else if in_data > second (strict): second<=in_data.
  - Ties keep the lower index; an equal value may still raise second.
  - When the sample with counter==N_OUT-1 is accepted, the next state is DONE.
    - res_valid rises on the clock edge after that sample, i.e. 1-cycle latency.
    - res_value, res_index and res_margin are registered on the same edge.
  - res_margin = max - second, computed in DW+1 bits; never negative. Range 0..2^DW-1.
  - in_valid gaps of any length are allowed; no timeout.
  - start while in COLLECT restarts: counter and trackers are re-initialised, and a sample in the same cycle is dropped.
- DONE (res_valid=1): outputs are held stable until acknowledged.
  - res_ack -> IDLE, with res_valid=0 on the next cycle. res_index, res_value and res_margin keep their values until the next result is registered.
  - in_valid in DONE sets overflow (sticky) and the sample is discarded.
  - start in DONE (with or without res_ack): start wins. res_valid drops and the block enters COLLECT with cleared trackers. This is an implicit ack.
- res_ack outside DONE has no effect.
- Counter is IW bits and never wraps in COLLECT, because the transition happens at N_OUT-1.
- reset mid-COLLECT discards partial data; no result is produced.
- N_OUT=1 is legal: res_index=0 and res_margin = in_data - MIN_VAL.

Decomposition:
- Package fc_pkg holds:
  - DW, N_OUT, IW defaults;
  - MIN_VAL constant;
  - state enum {IDLE, COLLECT, DONE};
  - a margin width constant (DW+1).
- One sub-module, fc_top2_tracker, holds max/second/idx registers with a clear input and an update input. Its combinational outputs are the compare results.
- fc_argmax_out owns the FSM, counter, handshake and output registers.

Test Plan:
- Ascending ramp: reset, start, 256 samples in_data=index-128 back-to-back. Required: res_valid 1 cycle after the last sample; res_index=255, res_value=127, res_margin=1.
- Ties and negatives: all 256 samples=-5 except idx 17=300 and idx 200=300. Required: res_index=17, res_value=300, res_margin=0.
- Extremes with gaps: idx 3=32767, idx 9=-32768, rest -32768, with in_valid toggling every other cycle. Required: res_index=3, res_margin=65535.
- Handshake and overflow: complete a run, then hold res_ack=0 for 10 cycles while pulsing in_valid once. Required: outputs stable, overflow=1. Then res_ack: res_valid=0 next cycle, state IDLE, overflow still 1 until the next start.
- Restart mid-run: start, 100 samples with max 50 at idx 40, then start again with in_valid=1 in the same cycle, then 256 samples peaking 900 at idx 7. Required: res_index=7, res_value=900, and the sample in the start cycle is not counted.
- Async reset mid-COLLECT after 128 samples: all outputs return to reset values immediately. A later start plus 256 samples produces a correct fresh result.
